// File: rtl/tone_decoder.sv
// Tone decoder: turns one stable band-pass tone into a drive command, holds it
// until it is consumed or times out, then waits for band silence before re-arming.
module tone_decoder #(
  parameter int QUAL_CYCLES = 2_500_000,
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int GAP_CYCLES  = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bp1,
  input  logic       bp2,
  input  logic       bp3,
  input  logic       bp4,
  input  logic       bp5,
  input  logic       tdAck,
  output logic       tdEn,
  output logic [1:0] tdDir,
  output logic [1:0] tdState
);
  // state   | meaning
  // IDLE    | waiting for exactly one direction tone without cancel
  // QUALIFY | candidate tone must persist QUAL_CYCLES
  // VALID   | command presented on tdEn/tdDir until ack, cancel or timeout
  // HOLDOFF | all direction tones must stay low GAP_CYCLES before re-arming
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    QUALIFY = 2'b01,
    VALID   = 2'b10,
    HOLDOFF = 2'b11
  } state_t;

  localparam logic [26:0] QUAL_TC = 27'(QUAL_CYCLES - 1);
  localparam logic [26:0] HOLD_TC = 27'(HOLD_CYCLES - 1);
  localparam logic [26:0] GAP_TC  = 27'(GAP_CYCLES - 1);

  state_t      state, stateNext;
  logic [26:0] cnt, cntNext;
  logic [1:0]  cand, candNext;
  logic [1:0]  dirNext;
  logic [4:0]  syncA, syncB;
  logic        s1, s2, s3, s4, s5;
  logic [3:0]  tones, candHot;
  logic        single;
  logic [1:0]  toneCode;

  always_ff @(posedge clk) begin
    if (rst) begin
      syncA <= '0;
      syncB <= '0;
    end else begin
      syncA <= {bp5, bp4, bp3, bp2, bp1};
      syncB <= syncA;
    end
  end

  assign {s5, s4, s3, s2, s1} = syncB;
  assign tones   = {s4, s3, s2, s1};
  assign candHot = 4'b0001 << cand;

  always_comb begin
    single   = 1'b0;
    toneCode = 2'b00;
    case (tones)
      4'b0001: begin single = 1'b1; toneCode = 2'b00; end
      4'b0010: begin single = 1'b1; toneCode = 2'b01; end
      4'b0100: begin single = 1'b1; toneCode = 2'b10; end
      4'b1000: begin single = 1'b1; toneCode = 2'b11; end
      default: ;
    endcase
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    candNext  = cand;
    dirNext   = tdDir;
    case (state)
      IDLE: begin
        cntNext = '0;
        if (single && !s5) begin
          stateNext = QUALIFY;
          candNext  = toneCode;
        end
      end
      QUALIFY: begin
        if (tones == candHot && !s5) begin
          if (cnt == QUAL_TC) begin
            stateNext = VALID;
            dirNext   = cand;
            cntNext   = '0;
          end else begin
            cntNext = cnt + 27'd1;
          end
        end else begin
          stateNext = IDLE;
          cntNext   = '0;
        end
      end
      VALID: begin
        // ack, cancel and timeout all funnel into one exit
        if (tdAck || s5 || cnt == HOLD_TC) begin
          stateNext = HOLDOFF;
          cntNext   = '0;
        end else begin
          cntNext = cnt + 27'd1;
        end
      end
      HOLDOFF: begin
        if (tones != 4'b0000) begin
          cntNext = '0;
        end else if (cnt == GAP_TC) begin
          stateNext = IDLE;
          cntNext   = '0;
        end else begin
          cntNext = cnt + 27'd1;
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= 2'b00;
      tdDir <= 2'b00;
      tdEn  <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      cand  <= candNext;
      tdDir <= dirNext;
      tdEn  <= (stateNext == VALID);
    end
  end

  assign tdState = state;
endmodule

// File: doc/tone_decoder.md
TONE_DECODER -- requirements
Module: tone_decoder

Interface
REQ-001 The block SHALL expose parameter QUAL_CYCLES, default 2_500_000, meaning cycles a single tone must persist to qualify (50 ms at 50 MHz).
REQ-002 The block SHALL expose parameter HOLD_CYCLES, default 100_000_000, meaning maximum cycles tdEn stays high without tdAck (2 s).
REQ-003 The block SHALL expose parameter GAP_CYCLES, default 5_000_000, meaning cycles bp1..bp4 must all be low before re-arming (100 ms).
REQ-004 The block SHALL have the port clk, input, width 1, the single system clock (50 MHz).
REQ-005 The block SHALL have the port rst, input, width 1, a synchronous active-high reset.
REQ-006 The block SHALL have the ports bp1, bp2, bp3 and bp4, each input, width 1, asynchronous band-pass detector outputs for STRAIGHT, LEFT, RIGHT and BACK respectively.
REQ-007 The block SHALL have the port bp5, input, width 1, an asynchronous band-pass detector output for the cancel tone.
REQ-008 The block SHALL have the port tdAck, input, width 1, a one-cycle pulse from the drive state machine consuming the command.
REQ-009 The block SHALL have the port tdEn, output, width 1, high while a qualified command is valid.
REQ-010 The block SHALL have the port tdDir, output, width 2, the command code (00 STRAIGHT, 01 LEFT, 10 RIGHT, 11 BACK).
REQ-011 The block SHALL have the port tdState, output, width 2, the current FSM state for LED debug.

Function
REQ-012 bp1..bp5 SHALL each pass through a 2-flop synchronizer; all logic SHALL use only the synchronized copies (s1..s5).
REQ-013 The FSM SHALL have states IDLE=00, QUALIFY=01, VALID=10, HOLDOFF=11, and tdState SHALL equal the state encoding.
REQ-014 In IDLE, when exactly one of s1..s4 is high and s5 is low, the FSM SHALL go to QUALIFY, capture that channel's code as the candidate, and clear the 27-bit counter.
REQ-015 In IDLE, when zero or two or more of s1..s4 are high, or s5 is high, the FSM SHALL remain in IDLE.
REQ-016 In QUALIFY, while only the candidate channel is high and s5 is low, the counter SHALL increment by 1 per cycle.
REQ-017 In QUALIFY, in the cycle where the counter equals QUAL_CYCLES-1 with the qualify condition still true, the FSM SHALL enter VALID on the next edge, with tdEn<=1, tdDir<=candidate, and the counter cleared.
REQ-018 In QUALIFY, if the candidate drops, any other of s1..s4 rises, or s5 rises, the FSM SHALL return to IDLE with the counter cleared and tdEn remaining 0.
REQ-019 tdEn SHALL rise exactly QUAL_CYCLES+3 edges after the first edge that samples a clean single tone high.
REQ-020 In VALID, tdEn SHALL be 1 and tdDir SHALL be held constant, and the counter SHALL increment each cycle.
REQ-021 VALID SHALL exit to HOLDOFF on tdAck, on the counter reaching HOLD_CYCLES-1, or on s5 high; on exit tdEn<=0 and the counter is cleared.
REQ-022 When tdAck, timeout and s5 coincide, the FSM SHALL take the single transition to HOLDOFF, with no double action.
REQ-023 In VALID, changes on s1..s4 SHALL be ignored.
REQ-024 tdAck outside VALID SHALL be ignored.
REQ-025 In HOLDOFF, the counter SHALL increment while s1..s4 are all low and clear whenever any of them is high.
REQ-026 In HOLDOFF, at count GAP_CYCLES-1 the FSM SHALL go to IDLE, so that a held tone never re-triggers.
REQ-027 tdDir SHALL retain its last value after tdEn falls; consumers SHALL qualify it with tdEn.
REQ-028 The counter SHALL be 27 bits and SHALL never wrap: every terminal compare forces a clear or a state change first.
REQ-029 Parameters SHALL be at least 1, and all parameter values SHALL fit in 27 bits.

Reset
REQ-030 When rst is high at a clock edge, the next state SHALL be IDLE, with tdEn=0, tdDir=00, tdState=00, the counter=0, the candidate=00, and all synchronizer flops=0.
REQ-031 Reset SHALL take priority over every other event.
REQ-032 Reset asserted mid-QUALIFY or mid-VALID SHALL drop tdEn on the next edge.
REQ-033 After reset deasserts, a tone already present SHALL requalify from zero (full QUAL_CYCLES+3 latency).

Verification (QUAL_CYCLES=8, HOLD_CYCLES=40, GAP_CYCLES=4)
REQ-034 Scenario: bp3 high continuously -> tdEn=1 with tdDir=10 at edge 11; tdAck pulse at edge 15 -> tdEn=0 at edge 16, tdState=11.
REQ-035 Scenario: bp2 high for 6 cycles then low -> tdEn stays 0, tdState returns to 00.
REQ-036 Scenario: bp1 and bp4 high together -> tdState stays 00 and tdEn stays 0; dropping bp4 -> tdEn rises 11 edges later with tdDir=00.
REQ-037 Scenario: bp4 qualified, no tdAck -> tdEn falls after 40 VALID cycles; bp4 still held -> no re-trigger until 4 low cycles then a fresh 11-edge qualify.
REQ-038 Scenario: during VALID, bp5 high, or tdAck together with timeout in the same cycle -> exactly one exit to HOLDOFF, with tdEn=0 next edge.
REQ-039 Scenario: rst pulsed during VALID -> next edge tdEn=0, tdDir=00, tdState=00; tone held -> requalifies after 11 edges.
